// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // True when the access must not be issued: bad funct3 for the kind, or misaligned.
   function automatic logic access_is_fault(input logic       is_load,
                                            input logic [2:0] f3,
                                            input logic [1:0] a);
      logic fault;
      case (f3)
         F3_B:    fault = 1'b0;
         F3_H:    fault = a[0];
         F3_W:    fault = (a != 2'b00);
         F3_BU:   fault = !is_load;
         F3_HU:   fault = !is_load || a[0];
         default: fault = 1'b1;
      endcase
      return fault;
   endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/half lane of a read word and sign/zero-extends it.
module load_formatter
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection and extension.
   always_comb begin
      case (byte_off)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data = {24'h0, byte_sel};
         F3_H:    data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data = {16'h0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: request/ready handshake to data memory with store lane
// formatting, load extension and a stall to hold the core until completion.
module load_store_unit #(
   parameter int unsigned addr_data_width = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ld_en,
   input  logic                       st_en,
   input  logic [2:0]                 funct3,
   input  logic [addr_data_width-1:0] addr,
   input  logic [addr_data_width-1:0] st_data,
   output logic                       stall,
   output logic [addr_data_width-1:0] ld_data,
   output logic                       ld_valid,
   output logic                       access_fault,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [addr_data_width-1:0] mem_addr,
   output logic [addr_data_width-1:0] mem_wdata,
   output logic [3:0]                 mem_wstrb,
   input  logic                       mem_ready,
   input  logic [addr_data_width-1:0] mem_rdata
);
   import lsu_pkg::*;

   lsu_state_t                 state_q, state_d;
   logic [addr_data_width-1:0] addr_q, addr_d;
   logic [addr_data_width-1:0] st_data_q, st_data_d;
   logic [addr_data_width-1:0] ld_data_q, ld_data_d;
   logic [2:0]                 funct3_q, funct3_d;
   logic                       is_load_q, is_load_d;

   logic                       req;
   logic                       fault;
   logic                       accept;
   logic [addr_data_width-1:0] fmt_data;

   // A simultaneous ld_en/st_en is treated as a load.
   assign req    = ld_en || st_en;
   assign fault  = access_is_fault(ld_en, funct3, addr[1:0]);
   assign accept = (state_q == IDLE) && req && !fault;

   load_formatter u_load_formatter (
      .funct3   (funct3_q),
      .byte_off (addr_q[1:0]),
      .rdata    (mem_rdata),
      .data     (fmt_data)
   );

   // State and latched-access registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         st_data_q <= '0;
         ld_data_q <= '0;
         funct3_q  <= 3'b000;
         is_load_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         st_data_q <= st_data_d;
         ld_data_q <= ld_data_d;
         funct3_q  <= funct3_d;
         is_load_q <= is_load_d;
      end
   end

   // Next-state and latch capture.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      st_data_d = st_data_q;
      ld_data_d = ld_data_q;
      funct3_d  = funct3_q;
      is_load_d = is_load_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = BUSY;
               addr_d    = addr;
               st_data_d = st_data;
               funct3_d  = funct3;
               is_load_d = ld_en;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               state_d = DONE;
               if (is_load_q) begin
                  ld_data_d = fmt_data;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs; combinational ones are forced low while reset is held.
   always_comb begin
      stall        = 1'b0;
      access_fault = 1'b0;
      ld_valid     = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_wstrb    = 4'b0000;
      case (state_q)
         IDLE: begin
            stall        = accept;
            access_fault = req && fault;
         end
         BUSY: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_we   = !is_load_q;
            mem_addr = {addr_q[addr_data_width-1:2], 2'b00};
            if (!is_load_q) begin
               case (funct3_q)
                  F3_B: begin
                     mem_wstrb = 4'b0001 << addr_q[1:0];
                     mem_wdata = {4{st_data_q[7:0]}};
                  end
                  F3_H: begin
                     mem_wstrb = 4'b0011 << {addr_q[1], 1'b0};
                     mem_wdata = {2{st_data_q[15:0]}};
                  end
                  default: begin
                     mem_wstrb = 4'b1111;
                     mem_wdata = st_data_q;
                  end
               endcase
            end
         end
         default: ld_valid = is_load_q;
      endcase
      if (!reset) begin
         stall        = 1'b0;
         access_fault = 1'b0;
      end
   end

   assign ld_data = ld_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_en, st_en;
   logic [2:0]  funct3;
   logic [31:0] addr, st_data;
   logic        stall;
   logic [31:0] ld_data;
   logic        ld_valid, access_fault;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   load_store_unit #(.addr_data_width(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .ld_en        (ld_en),
      .st_en        (st_en),
      .funct3       (funct3),
      .addr         (addr),
      .st_data      (st_data),
      .stall        (stall),
      .ld_data      (ld_data),
      .ld_valid     (ld_valid),
      .access_fault (access_fault),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next negedge (away from the active edge).
   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      ld_en     = 1'b0;
      st_en     = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
   endtask

   task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_ld);
      step();
      st_en = 1'b1; funct3 = f3; addr = a; st_data = d; mem_ready = 1'b1;
      #1;
      chk("st_accept_stall", {31'h0, stall}, 32'h1);
      chk("st_accept_req", {31'h0, mem_req}, 32'h0);
      step();
      chk("st_busy_req", {31'h0, mem_req}, 32'h1);
      chk("st_busy_we", {31'h0, mem_we}, 32'h1);
      chk("st_busy_stall", {31'h0, stall}, 32'h1);
      chk("st_addr", mem_addr, {a[31:2], 2'b00});
      chk("st_wstrb", {28'h0, mem_wstrb}, {28'h0, exp_strb});
      chk("st_wdata", mem_wdata, exp_wdata);
      step();
      chk("st_done_stall", {31'h0, stall}, 32'h0);
      chk("st_done_valid", {31'h0, ld_valid}, 32'h0);
      chk("st_done_req", {31'h0, mem_req}, 32'h0);
      chk("st_ld_hold", ld_data, exp_ld);
      step();
      idle_inputs();
      #1;
      chk("st_idle_stall", {31'h0, stall}, 32'h0);
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input int waits,
                          input logic [31:0] rd, input logic [31:0] exp);
      step();
      ld_en = 1'b1; funct3 = f3; addr = a; mem_ready = 1'b1; mem_rdata = 32'hA5A5_A5A5;
      #1;
      chk("ld_accept_stall", {31'h0, stall}, 32'h1);
      chk("ld_accept_req", {31'h0, mem_req}, 32'h0);
      chk("ld_accept_valid", {31'h0, ld_valid}, 32'h0);
      for (int i = 0; i < waits; i++) begin
         step();
         mem_ready = 1'b0;
         #1;
         chk("ld_wait_req", {31'h0, mem_req}, 32'h1);
         chk("ld_wait_stall", {31'h0, stall}, 32'h1);
         chk("ld_wait_addr", mem_addr, {a[31:2], 2'b00});
      end
      step();
      mem_ready = 1'b1; mem_rdata = rd;
      #1;
      chk("ld_busy_req", {31'h0, mem_req}, 32'h1);
      chk("ld_busy_we", {31'h0, mem_we}, 32'h0);
      chk("ld_busy_wstrb", {28'h0, mem_wstrb}, 32'h0);
      chk("ld_busy_addr", mem_addr, {a[31:2], 2'b00});
      chk("ld_busy_stall", {31'h0, stall}, 32'h1);
      step();
      mem_rdata = 32'h0;
      #1;
      chk("ld_done_valid", {31'h0, ld_valid}, 32'h1);
      chk("ld_done_stall", {31'h0, stall}, 32'h0);
      chk("ld_done_req", {31'h0, mem_req}, 32'h0);
      chk("ld_data", ld_data, exp);
      step();
      idle_inputs();
      #1;
      chk("ld_pulse_end", {31'h0, ld_valid}, 32'h0);
      chk("ld_data_hold", ld_data, exp);
   endtask

   task automatic do_fault(input logic is_ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp_ld);
      step();
      ld_en = is_ld; st_en = !is_ld; funct3 = f3; addr = a; mem_ready = 1'b1;
      #1;
      chk("flt_fault", {31'h0, access_fault}, 32'h1);
      chk("flt_stall", {31'h0, stall}, 32'h0);
      chk("flt_req", {31'h0, mem_req}, 32'h0);
      step();
      chk("flt_stay_idle_req", {31'h0, mem_req}, 32'h0);
      idle_inputs();
      #1;
      chk("flt_clear", {31'h0, access_fault}, 32'h0);
      chk("flt_ld_hold", ld_data, exp_ld);
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      funct3 = 3'b010; addr = 32'h0; st_data = 32'h0;

      // Outputs held low in reset even with a request pending.
      step();
      ld_en = 1'b1;
      #1;
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_fault", {31'h0, access_fault}, 32'h0);
      chk("rst_req", {31'h0, mem_req}, 32'h0);
      chk("rst_ld_data", ld_data, 32'h0);
      chk("rst_valid", {31'h0, ld_valid}, 32'h0);
      ld_en = 1'b0;
      step();
      reset = 1'b1;

      do_store(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 32'h0);
      do_load(3'b000, 32'h0000_0103, 0, 32'h80FF_1234, 32'hFFFF_FF80);
      do_load(3'b100, 32'h0000_0103, 0, 32'h80FF_1234, 32'h0000_0080);
      do_store(3'b001, 32'h0000_0102, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080);
      do_store(3'b000, 32'h0000_0101, 32'h0000_0077, 4'b0010, 32'h7777_7777, 32'h0000_0080);
      do_load(3'b001, 32'h0000_0102, 0, 32'h8001_7FFF, 32'hFFFF_8001);
      do_load(3'b101, 32'h0000_0100, 0, 32'h8001_F00F, 32'h0000_F00F);
      do_load(3'b010, 32'h0000_0200, 5, 32'h1234_5678, 32'h1234_5678);

      do_fault(1'b1, 3'b010, 32'h0000_0102, 32'h1234_5678);
      do_fault(1'b0, 3'b001, 32'h0000_0101, 32'h1234_5678);
      do_fault(1'b1, 3'b011, 32'h0000_0100, 32'h1234_5678);
      do_fault(1'b0, 3'b100, 32'h0000_0100, 32'h1234_5678);

      // Reset asserted while BUSY abandons the access.
      step();
      ld_en = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300; mem_ready = 1'b0;
      step();
      #1;
      chk("rb_busy_req", {31'h0, mem_req}, 32'h1);
      reset = 1'b0;
      #1;
      chk("rb_req_drop", {31'h0, mem_req}, 32'h0);
      chk("rb_stall_drop", {31'h0, stall}, 32'h0);
      chk("rb_ld_clear", ld_data, 32'h0);
      step();
      idle_inputs();
      step();
      reset = 1'b1;
      #1;
      chk("rb_idle_req", {31'h0, mem_req}, 32'h0);
      chk("rb_idle_stall", {31'h0, stall}, 32'h0);
      do_load(3'b010, 32'h0000_0104, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
